// File: rtl/serial_add.sv
// Bit-serial adder: latches two WIDTH-bit operands and a carry-in, then adds them LSB-first
// through one full-adder cell. Optional subtract mode when SERIAL_ADD_SUB_EN is defined.
module serial_add #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             cout_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;
    logic             busy_nxt_s;
    logic             done_nxt_s;
    logic             accept_s;
    logic             last_s;
    logic             fa_s_s;
    logic             fa_cout_s;
    logic [WIDTH-1:0] b_load_s;
    logic             carry_load_s;

    fa u_fa (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .cin  (carry_r),
        .s    (fa_s_s),
        .cout (fa_cout_s)
    );

    // Accept and final-step qualifiers; subtraction is a + ~b + 1.
    always_comb begin
        accept_s = start && ((state_r == IDLE) || (state_r == DONE));
        last_s   = (state_r == RUN) && (cnt_r == LAST);
`ifdef SERIAL_ADD_SUB_EN
        if (sub) begin
            b_load_s     = ~b;
            carry_load_s = 1'b1;
        end else begin
            b_load_s     = b;
            carry_load_s = cin;
        end
`else
        b_load_s     = b;
        carry_load_s = cin;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = start ? RUN : IDLE;
            RUN:     state_nxt_s = last_s ? DONE : RUN;
            DONE:    state_nxt_s = start ? RUN : IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Status outputs decoded from the upcoming state so they can be registered.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            RUN:     busy_nxt_s = 1'b1;
            DONE:    done_nxt_s = 1'b1;
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Status output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    // Operand shifters, carry, counter and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept_s) begin
            a_r     <= a;
            b_r     <= b_load_s;
            sum_r   <= '0;
            cnt_r   <= '0;
            carry_r <= carry_load_s;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (state_r == RUN) begin
            a_r     <= {1'b0, a_r[WIDTH-1:1]};
            b_r     <= {1'b0, b_r[WIDTH-1:1]};
            sum_r   <= {fa_s_s, sum_r[WIDTH-1:1]};
            cnt_r   <= cnt_r + CW'(1);
            carry_r <= fa_cout_s;
            if (last_s) begin
                cout_r <= fa_cout_s;
                // Carry into the MSB differs from carry out of it on signed overflow.
                ovf_r  <= carry_r ^ fa_cout_s;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// One-bit full adder cell.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: tb/tb_serial_add.sv
// Self-checking bench for serial_add (WIDTH=16) against an arithmetic reference model.
module tb_serial_add;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks;
    int errors;

    serial_add #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-precision arithmetic, overflow from operand/result signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic s);
        logic [W:0]   full;
        logic [W-1:0] yy;
        logic         cc;
        logic         v;
        yy   = s ? ~y : y;
        cc   = s ? 1'b1 : c;
        full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
        v    = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        return {v, full};
    endfunction

    // Launch one op and wait (bounded) for done; lat = edges from accept to done.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         input logic ts, output int lat);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, sum, cout, ovf} !== {(W+4){1'b0}}) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
                     busy, done, sum, cout, ovf);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};
        logic [W-1:0] vb [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h8000};
        logic [W+1:0] exp_v;
        int lat;
        for (int k = 0; k < 4; k++) begin
            exp_v = model(va[k], vb[k], 1'b0, 1'b0);
            do_op(va[k], vb[k], 1'b0, 1'b0, lat);
            checks++;
            if (lat !== W) begin
                errors++;
                $display("FAIL directed_latency[%0d] got %0d expected %0d", k, lat, W);
            end
            checks++;
            if ({ovf, cout, sum} !== exp_v) begin
                errors++;
                $display("FAIL directed_result[%0d] got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                         k, ovf, cout, sum, exp_v[W+1], exp_v[W], exp_v[W-1:0]);
            end
        end
        // Anchor the model to the hand-derived boundary values.
        checks++;
        if (model(16'h7FFF, 16'h0001, 1'b0, 1'b0) !== {1'b1, 1'b0, 16'h8000}) begin
            errors++;
            $display("FAIL model_anchor got %h expected %h",
                     model(16'h7FFF, 16'h0001, 1'b0, 1'b0), {1'b1, 1'b0, 16'h8000});
        end
    endtask

    task automatic test_ignore_start();
        int ndone;
        int lat;
        logic [W-1:0] got;
        ndone = 0; lat = -1; got = '0;
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_accept got %b expected 1", busy);
        end
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = i;
                    got = sum;
                end
            end
            if (i == 3) begin
                start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
        end
        checks++;
        if (ndone !== 1 || lat !== W || got !== 16'h2346) begin
            errors++;
            $display("FAIL ignore_start got dones=%0d lat=%0d sum=%h expected dones=1 lat=%0d sum=2346",
                     ndone, lat, got, W);
        end
    endtask

    task automatic test_reset_mid_run();
        int ndone;
        int lat;
        ndone = 0;
        @(negedge clk);
        a = 16'h00FF; b = 16'h0F0F; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done, sum, cout, ovf} !== {(W+4){1'b0}}) begin
            errors++;
            $display("FAIL midrun_reset got busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
                     busy, done, sum, cout, ovf);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL midrun_no_done got %0d dones expected 0", ndone);
        end
        do_op(16'd3, 16'd4, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== W || sum !== 16'h0007) begin
            errors++;
            $display("FAIL after_reset_op got lat=%0d sum=%h expected lat=%0d sum=0007", lat, sum, W);
        end
    endtask

    task automatic test_back_to_back();
        int t [$];
        logic [W+1:0] r [$];
        @(negedge clk);
        a = 16'd1; b = 16'd2; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 a = 16'h8000; b = 16'h8000;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                t.push_back(i);
                r.push_back({ovf, cout, sum});
            end
            if (i == W + 1) start = 1'b0;
        end
        checks++;
        if (t.size() != 2) begin
            errors++;
            $display("FAIL b2b_count got %0d dones expected 2", t.size());
        end else begin
            checks++;
            if (t[1] - t[0] != W + 1 || t[0] != W) begin
                errors++;
                $display("FAIL b2b_spacing got first=%0d gap=%0d expected first=%0d gap=%0d",
                         t[0], t[1] - t[0], W, W + 1);
            end
            checks++;
            if (r[0] !== model(16'd1, 16'd2, 1'b0, 1'b0) || r[1] !== model(16'h8000, 16'h8000, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL b2b_results got %h,%h expected %h,%h", r[0], r[1],
                         model(16'd1, 16'd2, 1'b0, 1'b0), model(16'h8000, 16'h8000, 1'b0, 1'b0));
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W+1:0] exp_v;
        int lat;
        for (int k = 0; k < 30; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            exp_v = model(ra, rb, rc, 1'b0);
            do_op(ra, rb, rc, 1'b0, lat);
            checks++;
            if (lat !== W || {ovf, cout, sum} !== exp_v) begin
                errors++;
                $display("FAIL random[%0d] a=%h b=%h cin=%b got lat=%0d res=%h expected lat=%0d res=%h",
                         k, ra, rb, rc, lat, {ovf, cout, sum}, W, exp_v);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || {ovf, cout, sum} !== exp_v) begin
                errors++;
                $display("FAIL random_hold[%0d] got done=%b res=%h expected done=0 res=%h",
                         k, done, {ovf, cout, sum}, exp_v);
            end
        end
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        logic [W-1:0] va [2] = '{16'd5, 16'h8000};
        logic [W-1:0] vb [2] = '{16'd7, 16'd1};
        logic [W+1:0] exp_v;
        int lat;
        for (int k = 0; k < 2; k++) begin
            exp_v = model(va[k], vb[k], 1'b0, 1'b1);
            do_op(va[k], vb[k], 1'b0, 1'b1, lat);
            checks++;
            if (lat !== W || {ovf, cout, sum} !== exp_v) begin
                errors++;
                $display("FAIL sub[%0d] got lat=%0d res=%h expected lat=%0d res=%h",
                         k, lat, {ovf, cout, sum}, W, exp_v);
            end
        end
        sub = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
